switch_allocator: RTL

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/switch_allocator.sv
// switch_allocator: three-port (L/W/S) wormhole switch allocator.
// Each output port has its own lock FSM, round-robin arbiter and
// downstream credit counter. A port locks onto an input when a HEADER
// flit for it is seen, then streams that input's flits until a granted
// TAIL releases the lock.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   req[2:0]                  head-flit present per input (0=L,1=W,2=S)
//   Ldest/Wdest/Sdest         requested output per input (3 = invalid)
//   L/W/Sflit_type            head flit type (HEADER/BODY/TAIL)
//   credit_in[2:0]            one buffer slot returned per output port
//   grant[2:0]                per-input FIFO read enable (same-cycle transfer)
//   Lsel/Wsel/Ssel            crossbar select per output (3 = none)
//   out_valid[2:0]            per-output flit strobe
//   credit_err                sticky credit-overflow flag

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module switch_allocator #(
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [1:0] Ldest,
  input  logic [1:0] Wdest,
  input  logic [1:0] Sdest,
  input  logic [2:0] Lflit_type,
  input  logic [2:0] Wflit_type,
  input  logic [2:0] Sflit_type,
  input  logic [2:0] credit_in,
  output logic [2:0] grant,
  output logic [1:0] Lsel,
  output logic [1:0] Wsel,
  output logic [1:0] Ssel,
  output logic [2:0] out_valid,
  output logic       credit_err
);

  logic [2:0][1:0] dest;
  logic [2:0][2:0] ftype;
  logic [2:0]      hdr, tail;
  logic [2:0]      locked, perr, pov;
  logic [2:0][1:0] owner, sel;
  logic [2:0][2:0] busy, cand, pgrant;

  assign dest  = {Sdest, Wdest, Ldest};
  assign ftype = {Sflit_type, Wflit_type, Lflit_type};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hdr[i]  = (ftype[i] == `HEADER);
      tail[i] = (ftype[i] == `TAIL);
    end
  end

  // An input already holding some other output may not start a second
  // packet elsewhere; this keeps at most one grant bit per input.
  always_comb begin
    busy = '0;
    cand = '0;
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < 3; q++)
        for (int i = 0; i < 3; i++)
          if (q != p && locked[q] && owner[q] == 2'(i)) busy[p][i] = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++)
        cand[p][i] = req[i] && hdr[i] && (dest[i] == 2'(p)) && !busy[p][i];
  end

  for (genvar p = 0; p < 3; p++) begin : g_port
    switch_allocator_port #(.CREDITS(CREDITS)) u_port (
      .clk       (clk),
      .rst       (rst),
      .cand      (cand[p]),
      .req       (req),
      .tail      (tail),
      .credit_in (credit_in[p]),
      .grant     (pgrant[p]),
      .sel       (sel[p]),
      .out_valid (pov[p]),
      .locked    (locked[p]),
      .owner     (owner[p]),
      .credit_err(perr[p])
    );
  end

  assign grant      = pgrant[0] | pgrant[1] | pgrant[2];
  assign out_valid  = pov;
  assign Lsel       = sel[0];
  assign Wsel       = sel[1];
  assign Ssel       = sel[2];
  assign credit_err = |perr;

endmodule

// switch_allocator_port: one output port's lock FSM, round-robin
// pointer (last served input) and credit counter.
//   cand       inputs eligible to start a packet on this port
//   req, tail  head-flit present / head flit is TAIL, per input
//   credit_in  returned downstream slot
//   grant      one-hot read enable toward the owning input
//   sel        owner while locked, 3 when idle
//   locked, owner  lock status for cross-port eligibility
//   credit_err sticky overflow flag
module switch_allocator_port #(
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cand,
  input  logic [2:0] req,
  input  logic [2:0] tail,
  input  logic       credit_in,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       locked,
  output logic [1:0] owner,
  output logic       credit_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [3:0] CMAX   = 4'(CREDITS);

  logic [0:0] state;
  logic [1:0] owner_q, ptr_q, win;
  logic [3:0] cnt_q;
  logic       err_q, win_vld, send;

  // Search starts just after the last served input, so it ends up last.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    for (int k = 1; k <= 3; k++) begin
      int j;
      j = (int'(ptr_q) + k) % 3;
      if (!win_vld && cand[j]) begin
        win_vld = 1'b1;
        win     = 2'(j);
      end
    end
  end

  assign locked     = (state == LOCKED);
  assign send       = locked && req[owner_q] && (cnt_q != 4'd0);
  assign grant      = send ? (3'b001 << owner_q) : 3'b000;
  assign out_valid  = send;
  assign sel        = locked ? owner_q : 2'd3;
  assign owner      = owner_q;
  assign credit_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd2;  // S last => L > W > S
      cnt_q   <= CMAX;
      err_q   <= 1'b0;
    end else begin
      // Allocation is only evaluated in IDLE, so a port releasing on TAIL
      // cannot re-grant in the same cycle.
      case (state)
        IDLE: if (win_vld) begin
          state   <= LOCKED;
          owner_q <= win;
        end
        default: if (send && tail[owner_q]) begin
          state <= IDLE;
          ptr_q <= owner_q;
        end
      endcase

      if (send && !credit_in)
        cnt_q <= cnt_q - 4'd1;
      else if (!send && credit_in) begin
        if (cnt_q == CMAX) err_q <= 1'b1;
        else               cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule
